// File: rtl/uart_tx_fifo.sv
// Byte-oriented UART transmitter with a small FIFO; 8N1 frames, or 8E1 when
// UART_TX_PARITY_EN is defined. rst_n is asynchronous and active-high.
module uart_tx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    input  logic [7:0]                    wr_data,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_RELOAD = CW'(DIV - 1);
    localparam logic [AW:0]   FULL_LVL   = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
`ifdef UART_TX_PARITY_EN
    logic          parity;
`endif
    logic          push;
    logic          pop;
    logic          bit_done;
    logic          fifo_empty;

    assign wr_ready   = (fifo_level != FULL_LVL);
    assign fifo_empty = (fifo_level == '0);
    assign push       = wr_valid && wr_ready;
    assign bit_done   = (baud_cnt == '0);
    assign busy       = (state != S_IDLE) || !fifo_empty;

    // The head is popped from IDLE, or on the last STOP cycle so frames abut.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state == S_IDLE)
                pop = 1'b1;
            else if (state == S_STOP && bit_done)
                pop = 1'b1;
        end
    end

    // FIFO storage carries data only and is never cleared.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Shift register and parity are loaded at pop time from the FIFO head.
    always_ff @(posedge clk) begin
        if (pop) begin
            shift  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity <= ^mem[rd_ptr];
`endif
        end else if (state == S_DATA && bit_done) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state    <= S_START;
                        baud_cnt <= CNT_RELOAD;
                        tx       <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        state    <= S_DATA;
                        baud_cnt <= CNT_RELOAD;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        baud_cnt <= CNT_RELOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= parity;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_done) begin
                        state    <= S_STOP;
                        baud_cnt <= CNT_RELOAD;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            state    <= S_START;
                            baud_cnt <= CNT_RELOAD;
                            tx       <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a fast-baud instance checked every cycle against a
// frame-level model, and a default-parameter instance checked with literals.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int F_CLK  = 50_000_000;
    localparam int F_BAUD = 2_000_000;
    localparam int DIV    = F_CLK / F_BAUD;
    localparam int DEPTH  = 8;
    localparam int S_DIV  = 434;
`ifdef UART_TX_PARITY_EN
    localparam int          NB          = 11;
    localparam int          S_FRAME_LIT = 4774;
    localparam logic [10:0] LIT41       = 11'h482;
    localparam logic [10:0] LIT07       = 11'h60E;
`else
    localparam int          NB          = 10;
    localparam int          S_FRAME_LIT = 4340;
    localparam logic [10:0] LIT41       = 11'h282;
    localparam logic [10:0] LIT07       = 11'h20E;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, tx, busy;
    logic [3:0] fifo_level;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_ready, s_tx, s_busy;
    logic [3:0] s_level;

    uart_tx_fifo #(.CLK_HZ(F_CLK), .BAUD(F_BAUD), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(wr_ready), .tx(tx), .busy(busy), .fifo_level(fifo_level));

    uart_tx_fifo u_slow (
        .clk(clk), .rst_n(rst_n), .wr_valid(s_valid), .wr_data(s_data),
        .wr_ready(s_ready), .tx(s_tx), .busy(s_busy), .fifo_level(s_level));

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Frame-level model: a byte queue plus the byte on the wire and its elapsed time.
    logic [7:0] q[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_active = 1'b0;
    int         m_t = 0;

    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (NB == 11 && k == 9) return ^d;
        return 1'b1;
    endfunction

    initial forever begin
        bit acc;
        @(posedge clk or posedge rst_n);
        if (rst_n) begin
            q.delete();
            m_active = 1'b0;
            m_t = 0;
        end else begin
            acc = wr_valid && (q.size() != DEPTH);
            if (m_active) begin
                m_t++;
                if (m_t == NB * DIV) begin
                    if (q.size() != 0) begin
                        m_cur = q.pop_front();
                        m_t = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end else if (q.size() != 0) begin
                m_cur = q.pop_front();
                m_active = 1'b1;
                m_t = 0;
            end
            if (acc) q.push_back(wr_data);
        end
    end

    initial forever begin
        logic e_tx;
        @(negedge clk);
        if (chk_en && !rst_n) begin
            e_tx = m_active ? frame_bit(m_cur, m_t / DIV) : 1'b1;
            chk("model_tx", tx, e_tx);
            chk("model_level", fifo_level, q.size());
            chk("model_ready", wr_ready, q.size() != DEPTH);
            chk("model_busy", busy, m_active || q.size() != 0);
            chk("level_bound", fifo_level <= DEPTH, 1);
        end
    end

    function automatic logic tx_of(input bit slow);
        return slow ? s_tx : tx;
    endfunction
    function automatic logic busy_of(input bit slow);
        return slow ? s_busy : busy;
    endfunction
    function automatic logic [3:0] lvl_of(input bit slow);
        return slow ? s_level : fifo_level;
    endfunction

    task automatic wait_idle();
        int g = 0;
        while ((busy || s_busy) && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("idle_reached", busy || s_busy, 0);
    endtask

    // Offers one byte on the fast port until accepted; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] d);
        bit a;
        int g = 0;
        wr_valid = 1'b1;
        wr_data = d;
        do begin
            a = wr_ready;
            @(negedge clk);
            g++;
        end while (!a && g < 4 * NB * DIV);
        wr_valid = 1'b0;
        chk("send_accepted", a, 1);
    endtask

    task automatic check_frame(input bit slow, input logic [7:0] d, input logic [10:0] lit,
                               input int flen, input string nm);
        int t0, dv, g;
        dv = slow ? S_DIV : DIV;
        @(negedge clk);
        if (slow) begin s_valid = 1'b1; s_data = d; end
        else begin wr_valid = 1'b1; wr_data = d; end
        @(negedge clk);
        s_valid = 1'b0;
        wr_valid = 1'b0;
        chk({nm, "_level_after_accept"}, lvl_of(slow), 1);
        chk({nm, "_busy_after_accept"}, busy_of(slow), 1);
        chk({nm, "_tx_still_idle"}, tx_of(slow), 1);
        @(negedge clk);
        chk({nm, "_start_fall"}, tx_of(slow), 0);
        t0 = cyc;
        for (int k = 0; k < NB; k++) begin
            while (cyc < t0 + k * dv + dv / 2) @(negedge clk);
            chk($sformatf("%s_bit%0d", nm, k), tx_of(slow), lit[k]);
        end
        g = 0;
        while (busy_of(slow) && g < NB * dv + 20) begin
            @(negedge clk);
            g++;
        end
        chk({nm, "_busy_drop"}, cyc - t0, flen);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, nxt, run, ret, tstart, g, zeros;
        bit in_run, a;

        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_ready", wr_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_slow_tx", s_tx, 1);
        chk("rst_slow_busy", s_busy, 0);
        rst_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        check_frame(1'b1, 8'h41, LIT41, S_FRAME_LIT, "slow41");
        check_frame(1'b1, 8'h07, LIT07, S_FRAME_LIT, "slow07");
        check_frame(1'b0, 8'h41, LIT41, NB * DIV, "fast41");
        check_frame(1'b0, 8'h07, LIT07, NB * DIV, "fast07");
        wait_idle();

        // FIFO full: bytes 0x00..0x0F offered back to back from idle.
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data = 8'h00;
        nxt = 0; run = 0; in_run = 1'b1; ret = -1; tstart = cyc; g = 0;
        while (nxt < 16 && g < 40 * NB * DIV) begin
            a = wr_ready;
            if (!a && in_run) begin
                in_run = 1'b0;
                chk("full_run_len", run, 9);
                chk("full_level", fifo_level, 8);
                chk("full_ready_low", wr_ready, 0);
            end
            if (a && !in_run && ret < 0) ret = cyc - tstart;
            if (a && in_run) run++;
            @(negedge clk);
            g++;
            if (a) begin
                nxt++;
                wr_data = 8'(nxt);
            end
        end
        wr_valid = 1'b0;
        chk("full_reached", in_run, 0);
        chk("full_ready_return", ret, 2 + NB * DIV);
        wait_idle();

        // Pointer wrap: 20 random bytes at random intervals while draining.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 120)) @(negedge clk);
            send(8'($urandom));
        end
        wait_idle();

        // Back-to-back: second byte written during the first frame's STOP bit.
        @(negedge clk);
        send(8'h55);
        @(negedge clk);
        chk("b2b_first_fall", tx, 0);
        t0 = cyc;
        while (cyc < t0 + (NB - 1) * DIV + DIV / 2) @(negedge clk);
        chk("b2b_in_stop", tx, 1);
        send(8'hAA);
        g = 0;
        while (tx && g < 2 * NB * DIV) begin
            @(negedge clk);
            g++;
        end
        chk("b2b_start_spacing", cyc - t0, NB * DIV);
        wait_idle();

        // Reset during data bit 3 of 0xA5 with three bytes queued.
        @(negedge clk);
        send(8'hA5);
        @(negedge clk);
        chk("rstmid_fall", tx, 0);
        t0 = cyc;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        while (cyc < t0 + 4 * DIV + DIV / 2) @(negedge clk);
        chk("rstmid_bit3", tx, 0);
        chk("rstmid_queued", fifo_level, 3);
        rst_n = 1'b1;
        #1;
        chk("rstmid_tx", tx, 1);
        chk("rstmid_level", fifo_level, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ready", wr_ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        zeros = 0;
        repeat (2 * NB * DIV) begin
            @(negedge clk);
            if (!tx) zeros++;
        end
        chk("rstmid_no_frame", zeros, 0);
        chk("rstmid_idle_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
